bcd_time_keeper: RTL and testbench
==================================

Name: bcd_time_keeper

Overview:
Downstream consumer of the button pulse stages. Keeps 24-hour time as packed BCD digits, advanced by an internal 1 Hz prescaler. Takes single-cycle adjust pulses (hours/minutes/seconds) from three button pulse instances. Also generates the clk_en strobe those button pulse instances run on, so one block owns all slow timing for the clock display path.

Parameters:
CLK_FREQ, 31500000, input clock frequency in Hz; the prescaler wraps at CLK_FREQ-1.
BUTTON_RATE, 10, button_en strobe rate in Hz; divide ratio is CLK_FREQ/BUTTON_RATE, integer, at least 2.
RESET_HRS, 12, decimal hour loaded at reset, 0..23.
RESET_MIN, 0, decimal minute loaded at reset, 0..59.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
adj_hrs  in  1  single-cycle pulse: increment hours
adj_min  in  1  single-cycle pulse: increment minutes
adj_sec  in  1  single-cycle pulse: clear seconds and resync prescaler
button_en  out  1  one-cycle strobe at BUTTON_RATE; drives button pulse clk_en
sec_tick  out  1  one-cycle strobe when seconds advance
hrs_t  out  2  hours tens, 0..2
hrs_u  out  4  hours units, 0..9 (0..3 when hrs_t=2)
min_t  out  3  minutes tens, 0..5
min_u  out  4  minutes units, 0..9
sec_t  out  3  seconds tens, 0..5
sec_u  out  4  seconds units, 0..9

Behaviour:
- Reset (asynchronous, reset_n low):
  - Hours and minutes load the BCD of RESET_HRS and RESET_MIN.
  - Seconds load 00.
  - Both prescalers load 0.
  - button_en and sec_tick are 0.
- Prescaler:
  - sec_div counts 0..CLK_FREQ-1.
  - sec_tick is registered, high for the one cycle after sec_div wraps.
  - Period is exactly CLK_FREQ cycles.
- Button prescaler:
  - Counts 0..CLK_FREQ/BUTTON_RATE-1, free-running and independent of adjustments.
  - button_en is registered and high one cycle per wrap.
- Time advance:
  - On an internal wrap, sec_u increments.
  - Each carry chain digit wraps at its limit: sec 59 -> 00 carries to min; min 59 -> 00 carries to hrs; hrs 23 -> 00, no carry out.
  - All digit updates land on the same edge; outputs change together with sec_tick rising, so there is 0 cycles of skew between sec_tick and the new value.
- Adjust, applied on the edge after the pulse is sampled high:
  - adj_hrs: hours +1 with wrap 23 -> 00; minutes and seconds unchanged.
  - adj_min: minutes +1 with wrap 59 -> 00; no carry into hours.
  - adj_sec: seconds -> 00 and sec_div -> 0, so the next sec_tick is exactly CLK_FREQ cycles later; no carry.
- Simultaneous events:
  - Carry into a field plus an adjust of the same field in one cycle: the field advances by exactly 1 (adjust absorbs carry).
  - adj_sec plus an internal wrap: adj_sec wins; seconds = 00, no carry, sec_tick suppressed that cycle.
  - Multiple adjust pulses in one cycle: each applies to its own field independently.
- Digit encoding: digits never leave legal BCD range.
  - hrs_u wraps at 9 when hrs_t<2, and at 3 when hrs_t=2.
  - A held adjust input is not level-sensitive beyond one increment per high cycle; upstream guarantees single-cycle pulses.
- Width rules: prescaler widths are $clog2 of the respective limit. Digit arithmetic is 4-bit unsigned, compare-then-reset, with no binary-to-BCD conversion.
- Reset mid-operation: counters return to reset values immediately, asynchronously; no pending carry or adjust survives.

Decomposition:
- Shared package/header holds the digit limit constants: SEC_T_MAX=5, MIN_T_MAX=5, DIGIT_U_MAX=9, HRS_T_MAX=2, HRS_U_MAX_AT_20=3.
- One sub-module is natural: bcd_mod_counter.
  - Two BCD digits; parameter TENS_MAX, UNITS_MAX.
  - Inputs inc and clear; output carry.
  - Instantiated for seconds and minutes.
- Hours stay inline because of the 23 special-case.

Test Plan:
1. CLK_FREQ=20, BUTTON_RATE=4, reset released -> time 12:00:00; button_en every 5 cycles; first sec_tick 20 cycles after reset, seconds 00 -> 01.
2. Preload via adj to 23:59:59, then one sec_tick -> 00:00:00 on the same edge, sec_tick=1, no stray carry.
3. At 10:59:30, pulse adj_min -> 10:00:30, hours unchanged; pulse adj_hrs at 23:xx -> 00:xx.
4. adj_sec 7 cycles after a tick (CLK_FREQ=20) -> seconds 00 next cycle; next sec_tick exactly 20 cycles after the adj_sec edge, not 13.
5. At 10:59:59, adj_min coincides with the wrap -> 11:00:00? No: minutes absorb the carry -> 10:00:00 (minutes +1 only, no hours carry). adj_sec coinciding with the wrap -> seconds 00, sec_tick low.
6. Assert reset_n mid-count at 05:43:21 -> outputs 12:00:00 asynchronously, before the next clk edge; button_en and sec_tick low.

Source files
------------

// File: rtl/bcd_time_keeper_pkg.sv
// Shared digit limits and reset-value helpers for the BCD time keeper.
// Every BCD digit comparison uses these limits.
package bcd_time_keeper_pkg;

    localparam logic [3:0] SEC_T_MAX       = 4'd5;
    localparam logic [3:0] MIN_T_MAX       = 4'd5;
    localparam logic [3:0] DIGIT_U_MAX     = 4'd9;
    localparam logic [3:0] HRS_T_MAX       = 4'd2;
    localparam logic [3:0] HRS_U_MAX_AT_20 = 4'd3;

    function automatic logic [3:0] bcd_tens(input int unsigned v);
        return 4'(v / 10);
    endfunction

    function automatic logic [3:0] bcd_units(input int unsigned v);
        return 4'(v % 10);
    endfunction

endpackage

// File: rtl/bcd_time_keeper_mod_counter.sv
// Two-digit BCD modulo counter (seconds or minutes field).
// The counter wraps at TENS_MAX:UNITS_MAX and flags a carry on that wrap. A clear overrides an increment.
module bcd_mod_counter
    import bcd_time_keeper_pkg::*;
#(
    parameter int         TENS_W    = 3,
    parameter logic [3:0] TENS_MAX  = 4'd5,
    parameter logic [3:0] UNITS_MAX = 4'd9,
    parameter logic [3:0] TENS_RST  = 4'd0,
    parameter logic [3:0] UNITS_RST = 4'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              clear,
    output logic [TENS_W-1:0] tens,
    output logic [3:0]        units,
    output logic              carry
);

    logic [TENS_W-1:0] tens_q, tens_d;
    logic [3:0]        units_q, units_d;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        carry   = 1'b0;
        if (clear) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc) begin
            if (units_q == UNITS_MAX) begin
                units_d = '0;
                if (tens_q == TENS_W'(TENS_MAX)) begin
                    tens_d = '0;
                    carry  = 1'b1;
                end else begin
                    tens_d = tens_q + 1'b1;
                end
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tens_q  <= TENS_W'(TENS_RST);
            units_q <= UNITS_RST;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/bcd_time_keeper.sv
// This module keeps 24-hour BCD time using a 1 Hz prescaler and accepts adjust pulses.
// It also generates the button_en strobe that clocks the button pulse stages.
module bcd_time_keeper
    import bcd_time_keeper_pkg::*;
#(
    parameter int CLK_FREQ    = 31500000,
    parameter int BUTTON_RATE = 10,
    parameter int RESET_HRS   = 12,
    parameter int RESET_MIN   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adj_hrs,
    input  logic       adj_min,
    input  logic       adj_sec,
    output logic       button_en,
    output logic       sec_tick,
    output logic [1:0] hrs_t,
    output logic [3:0] hrs_u,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u
);

    localparam int BTN_DIV   = CLK_FREQ / BUTTON_RATE;
    localparam int SEC_DIV_W = $clog2(CLK_FREQ);
    localparam int BTN_DIV_W = $clog2(BTN_DIV);
    localparam logic [SEC_DIV_W-1:0] SEC_DIV_LAST = SEC_DIV_W'(CLK_FREQ - 1);
    localparam logic [BTN_DIV_W-1:0] BTN_DIV_LAST = BTN_DIV_W'(BTN_DIV - 1);

    logic [SEC_DIV_W-1:0] sec_div_q, sec_div_d;
    logic [BTN_DIV_W-1:0] btn_div_q, btn_div_d;
    logic                 sec_tick_q, sec_tick_d;
    logic                 button_en_q, button_en_d;
    logic [1:0]           hrs_t_q, hrs_t_d;
    logic [3:0]           hrs_u_q, hrs_u_d;
    logic                 sec_inc, min_inc, hrs_inc;
    logic                 sec_carry, min_carry;

    always_comb begin
        sec_div_d   = sec_div_q + 1'b1;
        sec_tick_d  = 1'b0;
        btn_div_d   = btn_div_q + 1'b1;
        button_en_d = 1'b0;
        hrs_t_d     = hrs_t_q;
        hrs_u_d     = hrs_u_q;

        // A seconds resync wins over a natural wrap and swallows that tick
        if (adj_sec) begin
            sec_div_d = '0;
        end else if (sec_div_q == SEC_DIV_LAST) begin
            sec_div_d  = '0;
            sec_tick_d = 1'b1;
        end

        if (btn_div_q == BTN_DIV_LAST) begin
            btn_div_d   = '0;
            button_en_d = 1'b1;
        end

        sec_inc = sec_tick_d;
        min_inc = adj_min | sec_carry;
        // An adjusted field absorbs its incoming carry and never carries onward
        hrs_inc = adj_hrs | (min_carry & ~adj_min);

        if (hrs_inc) begin
            if (hrs_t_q == HRS_T_MAX[1:0] && hrs_u_q == HRS_U_MAX_AT_20) begin
                hrs_t_d = 2'd0;
                hrs_u_d = 4'd0;
            end else if (hrs_u_q == DIGIT_U_MAX) begin
                hrs_t_d = hrs_t_q + 2'd1;
                hrs_u_d = 4'd0;
            end else begin
                hrs_u_d = hrs_u_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_div_q   <= '0;
            btn_div_q   <= '0;
            sec_tick_q  <= 1'b0;
            button_en_q <= 1'b0;
            hrs_t_q     <= 2'(bcd_tens(RESET_HRS));
            hrs_u_q     <= bcd_units(RESET_HRS);
        end else begin
            sec_div_q   <= sec_div_d;
            btn_div_q   <= btn_div_d;
            sec_tick_q  <= sec_tick_d;
            button_en_q <= button_en_d;
            hrs_t_q     <= hrs_t_d;
            hrs_u_q     <= hrs_u_d;
        end
    end

    bcd_mod_counter #(
        .TENS_W   (3),
        .TENS_MAX (SEC_T_MAX),
        .UNITS_MAX(DIGIT_U_MAX),
        .TENS_RST (4'd0),
        .UNITS_RST(4'd0)
    ) u_sec (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (sec_inc),
        .clear  (adj_sec),
        .tens   (sec_t),
        .units  (sec_u),
        .carry  (sec_carry)
    );

    bcd_mod_counter #(
        .TENS_W   (3),
        .TENS_MAX (MIN_T_MAX),
        .UNITS_MAX(DIGIT_U_MAX),
        .TENS_RST (bcd_tens(RESET_MIN)),
        .UNITS_RST(bcd_units(RESET_MIN))
    ) u_min (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (min_inc),
        .clear  (1'b0),
        .tens   (min_t),
        .units  (min_u),
        .carry  (min_carry)
    );

    assign button_en = button_en_q;
    assign sec_tick  = sec_tick_q;
    assign hrs_t     = hrs_t_q;
    assign hrs_u     = hrs_u_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Scoreboard bench for bcd_time_keeper: the driver pushes model expectations, and the monitor pops them and compares.
// The reference model tracks time as integer h/m/s and tick edges by absolute edge number.
module tb_bcd_time_keeper;

    localparam int CLK_FREQ    = 20;
    localparam int BUTTON_RATE = 4;
    localparam int BTN_DIV     = CLK_FREQ / BUTTON_RATE;
    localparam int RESET_HRS   = 12;
    localparam int RESET_MIN   = 0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       adj_hrs = 1'b0, adj_min = 1'b0, adj_sec = 1'b0;
    logic       button_en, sec_tick;
    logic [1:0] hrs_t;
    logic [3:0] hrs_u, min_u, sec_u;
    logic [2:0] min_t, sec_t;

    bcd_time_keeper #(
        .CLK_FREQ   (CLK_FREQ),
        .BUTTON_RATE(BUTTON_RATE),
        .RESET_HRS  (RESET_HRS),
        .RESET_MIN  (RESET_MIN)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .adj_hrs  (adj_hrs),
        .adj_min  (adj_min),
        .adj_sec  (adj_sec),
        .button_en(button_en),
        .sec_tick (sec_tick),
        .hrs_t    (hrs_t),
        .hrs_u    (hrs_u),
        .min_t    (min_t),
        .min_u    (min_u),
        .sec_t    (sec_t),
        .sec_u    (sec_u)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit btn;
        bit tick;
        int h;
        int m;
        int s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: edge index since reset release, edge of the next due tick, and wall time
    int e, next_tick, mh, mm, ms;
    bit last_tick;
    bit prev_ah, prev_am, prev_as;

    function automatic logic [21:0] pack_exp(bit btn, bit tick, int h, int m, int s);
        return {btn, tick, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {button_en, sec_tick, hrs_t, hrs_u, min_t, min_u, sec_t, sec_u};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        e = 0;
        next_tick = CLK_FREQ;
        mh = RESET_HRS;
        mm = RESET_MIN;
        ms = 0;
        last_tick = 0;
    endtask

    task automatic step(input bit ah, input bit am, input bit as_);
        exp_t x;
        bit tick, csec, cmin;
        @(negedge clk);
        adj_hrs = ah;
        adj_min = am;
        adj_sec = as_;
        e++;
        tick = (e == next_tick) && !as_;
        if (as_) next_tick = e + CLK_FREQ;
        else if (e == next_tick) next_tick = next_tick + CLK_FREQ;
        csec = 0;
        cmin = 0;
        if (as_) ms = 0;
        else if (tick) begin
            ms = ms + 1;
            if (ms == 60) begin ms = 0; csec = 1; end
        end
        if (am) mm = (mm + 1) % 60;
        else if (csec) begin
            mm = mm + 1;
            if (mm == 60) begin mm = 0; cmin = 1; end
        end
        if (ah || cmin) mh = (mh + 1) % 24;
        last_tick = tick;
        x.btn  = (e % BTN_DIV) == 0;
        x.tick = tick;
        x.h = mh;
        x.m = mm;
        x.s = ms;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic wait_tick_edge();
        int g = 0;
        while (e + 1 != next_tick && g < 100) begin
            step(0, 0, 0);
            g++;
        end
    endtask

    task automatic goto_time(input int h, input int m, input int s);
        int g = 0;
        bit t = 0;
        while (!(mh == h && mm == m && ms == s) && g < 6000) begin
            t = !t;
            step(t && (mh != h), t && (mm != m), 0);
            g++;
        end
        checks++;
        if (g >= 6000) begin
            errors++;
            $display("FAIL goto_timeout reached=%0d:%0d:%0d required=%0d:%0d:%0d", mh, mm, ms, h, m, s);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 10) begin
            @(posedge clk);
            #2;
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
    endtask

    // Monitor: the DUT presents a new time value on every clock edge while out of reset
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (reset_n && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("cycle", dut_vec(), pack_exp(x.btn, x.tick, x.h, x.m, x.s));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check("reset_state", dut_vec(), pack_exp(0, 0, RESET_HRS, RESET_MIN, 0));
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Test 1: button strobe every 5 edges and first tick on edge 20
        idle(45);

        // Test 2: full rollover 23:59:59 -> 00:00:00 on the tick edge
        goto_time(23, 59, 59);
        wait_tick_edge();
        step(0, 0, 0);
        idle(3);

        // Test 3: minute adjust wraps without carry, then hour adjust wraps 23 -> 00
        goto_time(10, 59, 30);
        step(0, 1, 0);
        idle(2);
        for (int i = 0; i < 30 && mh != 23; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        step(1, 0, 0);
        idle(2);

        // Test 4: adj_sec 7 edges after a tick resyncs the prescaler
        for (int i = 0; i < 40 && !last_tick; i++) step(0, 0, 0);
        idle(6);
        step(0, 0, 1);
        idle(25);

        // Test 5: adjust coinciding with the natural wrap
        goto_time(10, 59, 59);
        wait_tick_edge();
        step(0, 1, 0);
        idle(3);
        wait_tick_edge();
        step(0, 0, 1);
        idle(3);
        wait_tick_edge();
        step(1, 1, 0);
        idle(3);

        // Random single-cycle pulses
        prev_ah = 0;
        prev_am = 0;
        prev_as = 0;
        for (int i = 0; i < 3000; i++) begin
            bit ah, am, as_;
            ah = !prev_ah && ($urandom_range(9) == 0);
            am = !prev_am && ($urandom_range(9) == 0);
            as_ = !prev_as && ($urandom_range(39) == 0);
            step(ah, am, as_);
            prev_ah = ah;
            prev_am = am;
            prev_as = as_;
        end
        idle(2);

        // Test 6: asynchronous reset mid-count
        goto_time(5, 43, 21);
        idle(5);
        drain();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), pack_exp(0, 0, RESET_HRS, RESET_MIN, 0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", dut_vec(), pack_exp(0, 0, RESET_HRS, RESET_MIN, 0));
        #2 reset_n = 1'b1;
        model_reset();
        idle(30);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
